csi2_packet_tx: RTL
===================

CSI2_PACKET_TX -- requirements
Module: csi2_packet_tx

Interface
REQ-001 Parameter LP_GAP, default 4: number of idle cycles, with both lanes inactive, after every packet.
REQ-002 Parameter SYNC_BYTE, default 8'hB8: HS leader byte driven on every lane at start of transmission.
REQ-003 clk  in  1  single clock domain; all logic on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 pkt_valid  in  1  packet request present.
REQ-006 pkt_ready  out  1  request accepted when pkt_valid and pkt_ready are both high.
REQ-007 pkt_vc  in  2  virtual channel.
REQ-008 pkt_dt  in  6  data type; 0x00-0x0F selects a short packet, all others select a long packet.
REQ-009 pkt_wc  in  16  long packet: payload byte count; short packet: 16-bit data field.
REQ-010 pay_data  in  16  payload beat; bits [7:0] are the earlier byte.
REQ-011 pay_valid  in  1  payload beat present.
REQ-012 pay_ready  out  1  payload beat consumed this cycle.
REQ-013 lane_data  out  16  bits [7:0] drive lane 0; bits [15:8] drive lane 1.
REQ-014 lane_hs  out  2  per-lane HS-active qualifier.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 underrun  out  1  one-cycle pulse when a required payload beat was missing.

Function
REQ-017 FSM states: IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC, GAP; each state except PAYLOAD and GAP lasts one cycle.
REQ-018 IDLE: pkt_ready=1 and lane_hs=00. On accept, latch vc/dt/wc and go to SYNC; SYNC outputs appear on the cycle after the accept.
REQ-019 pkt_ready is 0 in every state other than IDLE; the block accepts no pipelined requests.
REQ-020 SYNC: both lanes carry SYNC_BYTE; lane_hs=11.
REQ-021 Header bytes: B0={vc,dt}, B1=wc[7:0], B2=wc[15:8], B3={2'b00,ecc[5:0]}.
REQ-022 Header schedule: HDR0 drives lane0=B0, lane1=B1; HDR1 drives lane0=B2, lane1=B3.
REQ-023 ECC: 6-bit CSI-2 Hamming code over the 24 bits {B2,B1,B0}. Combinational. Parity masks come from the package.
REQ-024 Short packet: HDR1 is followed by GAP.
REQ-025 Long packet with wc=0: HDR1 is followed by CRC.
REQ-026 Long packet with wc>0: HDR1 is followed by PAYLOAD.
REQ-027 PAYLOAD: pay_ready=1 on every PAYLOAD cycle; each cycle consumes one beat (two bytes); duration ceil(wc/2) cycles.
REQ-028 Odd wc, final beat: lane0 carries pay_data[7:0]; pay_data[15:8] is ignored and excluded from the CRC; lane1 carries crc[7:0] in the same cycle.
REQ-029 Odd wc, following CRC cycle: lane0=crc[15:8], lane_hs=01, lane1 data=0x00.
REQ-030 Even wc, and wc=0, CRC cycle: lane0=crc[7:0], lane1=crc[15:8], lane_hs=11.
REQ-031 CRC: CRC-16 polynomial x^16+x^12+x^5+1, bit-reflected (0x8408), init 0xFFFF, no final XOR, bytes processed LSB first. It covers payload bytes only, 2 bytes per cycle, and is re-initialised on every accept.
REQ-032 Underrun: pay_valid=0 during PAYLOAD still advances the FSM. The missing bytes are sent as 0x00 and included in the CRC; underrun pulses for that cycle.
REQ-033 A payload beat is never stalled; the HS burst is never interrupted.
REQ-034 GAP: lane_hs=00 and lane_data=0 for LP_GAP cycles, then IDLE.
REQ-035 Whenever a lane's lane_hs bit is 0, that lane's data byte is 0x00.
REQ-036 Byte counter is 16 bits; wc=0xFFFF completes with no wrap (32768 payload cycles).

Reset
REQ-037 reset asserted in any cycle, including mid-packet: on the next edge the FSM is in IDLE.
REQ-038 Reset values: lane_hs=00, lane_data=0, busy=0, underrun=0, pay_ready=0, pkt_ready=1 from the first cycle after reset deasserts.
REQ-039 After reset the CRC register is 0xFFFF and the latched header fields are 0.
REQ-040 A packet truncated by reset is not resumed.

Structure
REQ-041 Package csi2_pkg holds:
- the data-type constants: FRAME_START 0x00, FRAME_END 0x01, LINE_START 0x02, LINE_END 0x03, RGB565 0x22, RAW8 0x2A;
- the short/long threshold 0x10;
- the six ECC parity masks;
- the CRC polynomial and init value;
- the FSM state enumeration.
REQ-042 The CRC is a separate sub-module, csi2_crc16, with 2-byte and 1-byte update modes; the receive path shares it.

Verification
REQ-043 Short packet, frame start, vc=0, wc=0x0000 -> exactly 3 HS cycles: B8/B8, 00/00, 00/00 (ECC 0x00), then 4 idle cycles.
REQ-044 Long packet, dt=0x2A, wc=9, payload 0x31..0x39 ("123456789") -> 5 payload cycles; lane1 of the 5th=0x91; next cycle lane0=0x6F, lane_hs=01.
REQ-045 Long packet, wc=0 -> CRC cycle carries FF/FF immediately after HDR1.
REQ-046 Header ECC -> matches the bench reference model over a 1000-case random vc/dt/wc sweep; ECC bits 7:6 always 0.
REQ-047 wc=4, pay_valid low on the 2nd beat -> bytes 3-4 sent as 00/00, underrun pulses once, CRC equals the model CRC over {b1,b2,00,00}.
REQ-048 reset asserted on the 2nd payload cycle -> next cycle lane_hs=00, pkt_ready=1; a new request is accepted and sent with a correct CRC.

Source files
------------

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data types, ECC parity masks, CRC constants and
// the transmitter state encoding.
package csi2_pkg;

  localparam logic [5:0] FRAME_START = 6'h00;
  localparam logic [5:0] FRAME_END   = 6'h01;
  localparam logic [5:0] LINE_START  = 6'h02;
  localparam logic [5:0] LINE_END    = 6'h03;
  localparam logic [5:0] RGB565      = 6'h22;
  localparam logic [5:0] RAW8        = 6'h2A;

  // Data types below this value carry no payload (short packets).
  localparam logic [5:0] SHORT_DT_LIMIT = 6'h10;

  // Index i selects the header bits {B2,B1,B0} that feed parity bit P[i].
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00,
    24'hDF03F0,
    24'hB8E38E,
    24'h749A6D,
    24'hF2555B,
    24'hF12CB7
  };

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HDR0,
    HDR1,
    PAYLOAD,
    CRC,
    GAP
  } tx_state_e;

  function automatic logic is_short_dt(input logic [5:0] dt);
    return dt < SHORT_DT_LIMIT;
  endfunction

  function automatic logic [5:0] calc_ecc(input logic [23:0] hdr);
    logic [5:0] p;
    for (int i = 0; i < 6; i++) begin
      p[i] = ^(hdr & ECC_MASK[i]);
    end
    return p;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Combinational CRC-16 (reflected 0x8408) update over one or two bytes,
// low byte first. Shared with the receive path.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data_in,
  input  logic        two_byte,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic [15:0] crc_lo;

  assign crc_lo  = crc_byte(crc_in, data_in[7:0]);
  assign crc_out = two_byte ? crc_byte(crc_lo, data_in[15:8]) : crc_lo;

endmodule

// File: rtl/csi2_packet_tx.sv
// Two-lane CSI-2 packet transmitter: SYNC leader, ECC-protected header,
// optional payload with CRC-16 trailer, then an LP gap.
module csi2_packet_tx
  import csi2_pkg::*;
#(
  parameter int         LP_GAP    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [1:0]  pkt_vc,
  input  logic [5:0]  pkt_dt,
  input  logic [15:0] pkt_wc,
  input  logic [15:0] pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [15:0] lane_data,
  output logic [1:0]  lane_hs,
  output logic        busy,
  output logic        underrun
);

  localparam int GAP_W = (LP_GAP > 1) ? $clog2(LP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((LP_GAP > 0) ? (LP_GAP - 1) : 0);
  localparam tx_state_e POST_PKT = (LP_GAP == 0) ? IDLE : GAP;

  tx_state_e        state_q, state_d;
  logic [1:0]       vc_q, vc_d;
  logic [5:0]       dt_q, dt_d;
  logic [15:0]      wc_q, wc_d;
  logic [15:0]      rem_q, rem_d;
  logic [15:0]      crc_q, crc_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [15:0] beat_data;
  logic [15:0] crc_upd;
  logic [5:0]  ecc;
  logic        last_beat;
  logic        odd_last;

  // A missing beat is replaced by zero bytes, which also enter the CRC.
  assign beat_data = pay_valid ? pay_data : 16'h0000;
  assign last_beat = (rem_q <= 16'd2);
  assign odd_last  = (state_q == PAYLOAD) && (rem_q == 16'd1);
  assign ecc       = calc_ecc({wc_q, vc_q, dt_q});

  csi2_crc16 u_crc (
    .crc_in   (crc_q),
    .data_in  (beat_data),
    .two_byte (!odd_last),
    .crc_out  (crc_upd)
  );

  always_comb begin
    state_d   = state_q;
    vc_d      = vc_q;
    dt_d      = dt_q;
    wc_d      = wc_q;
    rem_d     = rem_q;
    crc_d     = crc_q;
    gap_d     = '0;
    pkt_ready = 1'b0;
    pay_ready = 1'b0;
    lane_data = 16'h0000;
    lane_hs   = 2'b00;
    busy      = 1'b1;
    underrun  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        pkt_ready = !reset;
        if (pkt_valid && !reset) begin
          vc_d    = pkt_vc;
          dt_d    = pkt_dt;
          wc_d    = pkt_wc;
          crc_d   = CRC_INIT;
          state_d = SYNC;
        end
      end

      SYNC: begin
        lane_hs   = 2'b11;
        lane_data = {SYNC_BYTE, SYNC_BYTE};
        state_d   = HDR0;
      end

      HDR0: begin
        lane_hs   = 2'b11;
        lane_data = {wc_q[7:0], vc_q, dt_q};
        state_d   = HDR1;
      end

      HDR1: begin
        lane_hs   = 2'b11;
        lane_data = {2'b00, ecc, wc_q[15:8]};
        rem_d     = wc_q;
        if (is_short_dt(dt_q)) begin
          state_d = POST_PKT;
        end else if (wc_q == 16'h0000) begin
          state_d = CRC;
        end else begin
          state_d = PAYLOAD;
        end
      end

      // Never stalls: a beat is consumed every cycle whether or not it is present.
      PAYLOAD: begin
        lane_hs   = 2'b11;
        pay_ready = 1'b1;
        underrun  = !pay_valid;
        crc_d     = crc_upd;
        lane_data = odd_last ? {crc_upd[7:0], beat_data[7:0]} : beat_data;
        if (last_beat) begin
          state_d = CRC;
        end else begin
          rem_d = rem_q - 16'd2;
        end
      end

      CRC: begin
        if (wc_q[0]) begin
          lane_hs   = 2'b01;
          lane_data = {8'h00, crc_q[15:8]};
        end else begin
          lane_hs   = 2'b11;
          lane_data = crc_q;
        end
        state_d = POST_PKT;
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vc_q    <= '0;
      dt_q    <= '0;
      wc_q    <= '0;
      rem_q   <= '0;
      crc_q   <= CRC_INIT;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      dt_q    <= dt_d;
      wc_q    <= wc_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      gap_q   <= gap_d;
    end
  end

endmodule
